// File: rtl/alu_opctrl_pkg.sv
// Shared types and constants for the ALU operand controller.
package alu_opctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_CLEAR = 1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      btn_stable <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      // Any return to the accepted level restarts the stability window.
      if (sync2_q == btn_stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        btn_stable <= sync2_q;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      prev_q <= btn_stable;
      press  <= btn_stable & ~prev_q;
    end
  end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Stages operands A, B and opcode from the switches and issues them with a
// valid/ready handshake. Define ALU_OPCTRL_CNT_EN to add the op_cnt counter.
module alu_operand_ctrl
  import alu_opctrl_pkg::*;
#(
  parameter int unsigned DW           = 4,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       btn,
  input  logic [15:0]      sw,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  output logic [SEL_W-1:0] op_sel,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       stage
`ifdef ALU_OPCTRL_CNT_EN
  ,
  output logic [7:0]       op_cnt
`endif
);

  state_e state;
  logic   enter_press;
  logic   clear_press;
  logic   unused_enter_lvl;
  logic   unused_clear_lvl;
  logic   unused_in;

  assign unused_in = ^{btn[4:2], sw};

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_enter (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn[BTN_ENTER]),
    .btn_stable(unused_enter_lvl),
    .press     (enter_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_clear (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn[BTN_CLEAR]),
    .btn_stable(unused_clear_lvl),
    .press     (clear_press)
  );

  assign stage = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WAIT_A;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= '0;
      op_valid <= 1'b0;
    end else if (clear_press) begin
      // CLEAR outranks ENTER and a coincident handshake.
      state    <= WAIT_A;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= '0;
      op_valid <= 1'b0;
    end else begin
      unique case (state)
        WAIT_A: begin
          if (enter_press) begin
            op_a  <= sw[DW-1:0];
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_press) begin
            op_b     <= sw[2*DW-1:DW];
            op_sel   <= sw[15 -: SEL_W];
            op_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (enter_press) begin
            op_a  <= sw[DW-1:0];
            state <= WAIT_B;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

`ifdef ALU_OPCTRL_CNT_EN
  // Survives CLEAR; only reset zeroes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt <= '0;
    end else if (!clear_press && state == ISSUE && op_valid && op_ready) begin
      op_cnt <= op_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Scoreboard bench for alu_operand_ctrl with a short debounce window.
module tb_alu_operand_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned DC    = 4;
`ifdef ALU_OPCTRL_CNT_EN
  localparam int N_LOOP = 257;
`else
  localparam int N_LOOP = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       btn;
  logic [15:0]      sw;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic [SEL_W-1:0] op_sel;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       stage;
`ifdef ALU_OPCTRL_CNT_EN
  logic [7:0]       op_cnt;
`endif

  alu_operand_ctrl #(
    .DW          (DW),
    .SEL_W       (SEL_W),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .sw      (sw),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_sel  (op_sel),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .stage   (stage)
`ifdef ALU_OPCTRL_CNT_EN
    ,
    .op_cnt  (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
  } op_t;

  op_t exp_q[$];
  int  n_cmp   = 0;
  int  n_err   = 0;
  int  n_hs    = 0;
  int  exp_cnt = 0;
  bit  skip_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick(10);
    btn[idx] = 1'b0;
    tick(8);
  endtask

  task automatic wait_stage(input logic [1:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget && stage !== exp; i++) tick(1);
    check(tag, stage, exp);
  endtask

  function automatic logic [15:0] mk_sw(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    return {sel, 5'b0, b, a};
  endfunction

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    sw = mk_sw(a, b, sel);
    press(0);
    check("loop_stage_b", stage, 2'd1);
    check("loop_a", op_a, a);
    exp_q.push_back(op_t'{a: a, b: b, sel: sel});
    press(0);
    check("loop_stage_done", stage, 2'd3);
    check("loop_valid_low", op_valid, 1'b0);
  endtask

  // Scoreboard: every accepted handshake pops one expected operation.
  always @(negedge clk) begin : monitor
    op_t e;
    if (rst === 1'b1 && op_valid === 1'b1 && op_ready === 1'b1 && !skip_hs) begin
      n_hs++;
      exp_cnt = (exp_cnt + 1) % 256;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("xfer_a", op_a, e.a);
        check("xfer_b", op_b, e.b);
        check("xfer_sel", op_sel, e.sel);
      end
    end
  end

  initial begin : stim
    int lat;
    int hs_base;
    rst      = 1'b0;
    btn      = '0;
    sw       = '0;
    op_ready = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      btn = 5'($urandom);
      sw  = 16'($urandom);
      tick(1);
    end
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_sel", op_sel, 0);
    check("rst_valid", op_valid, 0);
    check("rst_stage", stage, 0);
`ifdef ALU_OPCTRL_CNT_EN
    check("rst_cnt", op_cnt, 0);
`endif
    btn = '0;
    sw  = 16'b101_0_0000_0110_0011;
    rst = 1'b1;
    tick(5);
    check("post_rst_stage", stage, 0);
    check("post_rst_valid", op_valid, 0);

    // Bounces shorter than the window are rejected.
    btn[0] = 1'b1; tick(3);
    btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(3);
    btn[0] = 1'b0; tick(12);
    check("bounce_stage", stage, 0);
    check("bounce_op_a", op_a, 0);

    // Held press: FSM reacts 2 + DC + 1 + 1 edges after the raw edge.
    btn[0] = 1'b1;
    lat    = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (lat == 0 && stage == 2'd1) lat = i;
    end
    check("press_latency", lat, 2 + DC + 2);
    btn[0] = 1'b0;
    tick(8);
    check("one_press_stage", stage, 1);
    check("cap_a", op_a, 3);

    // Second ENTER under backpressure.
    exp_q.push_back(op_t'{a: 4'd3, b: 4'd6, sel: 3'd5});
    press(0);
    check("issue_stage", stage, 2);
    check("issue_a", op_a, 3);
    check("issue_b", op_b, 6);
    check("issue_sel", op_sel, 5);
    check("issue_valid", op_valid, 1);

    sw     = 16'hFFFF;
    btn[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 10) btn[0] = 1'b0;
      check("bp_hold", {op_valid, stage, op_sel, op_b, op_a}, {1'b1, 2'd2, 3'd5, 4'd6, 4'd3});
    end
    tick(8);
    op_ready = 1'b1;
    wait_stage(2'd3, 10, "xfer_done_stage");
    tick(3);
    check("hs_count_1", n_hs, 1);
    check("done_valid", op_valid, 0);
    check("done_hold_a", op_a, 3);

    // DONE: ENTER recaptures A and keeps B.
    sw = mk_sw(4'd9, 4'd0, 3'd0);
    press(0);
    check("recap_stage", stage, 1);
    check("recap_a", op_a, 9);
    check("recap_hold_b", op_b, 6);
    sw = mk_sw(4'd0, 4'd10, 3'd2);
    exp_q.push_back(op_t'{a: 4'd9, b: 4'd10, sel: 3'd2});
    press(0);
    check("ready_high_stage", stage, 3);
    check("hs_count_2", n_hs, 2);

    // CLEAR from DONE, then from WAIT_B.
    sw = mk_sw(4'd7, 4'd1, 3'd1);
    press(1);
    check("clr_done_stage", stage, 0);
    check("clr_done_b", op_b, 0);
    press(0);
    check("wb_stage", stage, 1);
    press(1);
    check("clr_wb_stage", stage, 0);
    check("clr_wb_a", op_a, 0);

    // CLEAR lands on the same edge as a handshake.
    op_ready = 1'b0;
    sw = mk_sw(4'd5, 4'd12, 3'd6);
    press(0);
    exp_q.push_back(op_t'{a: 4'd5, b: 4'd12, sel: 3'd6});
    press(0);
    check("pre_clr_stage", stage, 2);
    btn[1] = 1'b1;
    tick(2 + DC + 1);
    skip_hs  = 1'b1;
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    skip_hs  = 1'b0;
    void'(exp_q.pop_back());
    check("clr_hs_valid", op_valid, 0);
    check("clr_hs_stage", stage, 0);
    check("clr_hs_ops", {op_sel, op_b, op_a}, 0);
    check("clr_hs_count", n_hs, 2);
`ifdef ALU_OPCTRL_CNT_EN
    check("clr_hs_cnt", op_cnt, exp_cnt);
`endif
    tick(2);
    btn[1] = 1'b0;
    tick(8);

    // Async reset mid-operation, with a partial press in flight.
    sw = mk_sw(4'd4, 4'd2, 3'd3);
    press(0);
    check("pre_arst_a", op_a, 4);
    btn[0] = 1'b1;
    tick(5);
    #2 rst = 1'b0;
    #1;
    check("arst_stage", stage, 0);
    check("arst_a", op_a, 0);
    btn[0] = 1'b0;
    tick(2);
    rst     = 1'b1;
    exp_cnt = 0;
    tick(12);
    check("arst_no_press", stage, 0);
`ifdef ALU_OPCTRL_CNT_EN
    check("arst_cnt", op_cnt, 0);
`endif

    // Back-to-back operations with op_ready tied high.
    op_ready = 1'b1;
    hs_base  = n_hs;
    for (int n = 0; n < N_LOOP; n++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)));
    end
    check("loop_hs_count", n_hs - hs_base, N_LOOP);
`ifdef ALU_OPCTRL_CNT_EN
    check("loop_cnt_wrap", op_cnt, N_LOOP % 256);
`endif
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
